// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// Generates PC/nPC/IF-ID load enables, the IF/ID flush, the NOP mux select,
// the back-end freeze, and forwarding selects for both ALU operands and store data.
// Control handshake: the pipeline advances one stage per Clk edge only when the
// relevant load enable is 1; a data-memory access is accepted (DM_ready=1) in the
// same cycle it completes, and until then the back end is frozen by pipe_hold.
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             R,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       ID_rd,
    input  logic             ID_i_bit,
    input  logic             ID_store,
    input  logic             ID_B_instr,
    input  logic             ID_29_a,
    input  logic [3:0]       ID_cond,
    input  logic             branch_taken,
    input  logic [4:0]       EX_rd,
    input  logic [4:0]       MEM_rd,
    input  logic [4:0]       WB_rd,
    input  logic             EX_RF_enable,
    input  logic             MEM_RF_enable,
    input  logic             WB_RF_enable,
    input  logic             EX_load_instr,
    input  logic             EX_modifyCC,
    input  logic             MEM_load_instr,
    input  logic             DM_ready,
    output logic             PC_LE,
    output logic             nPC_LE,
    output logic             IF_ID_LE,
    output logic             IF_ID_flush,
    output logic             mux_S,
    output logic             pipe_hold,
    output logic [1:0]       fwd_A,
    output logic [1:0]       fwd_B,
    output logic [1:0]       fwd_C,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic             dbg_state
);

    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [3:0] COND_BA = 4'b1000;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic hold_c;
    logic load_use_c;
    logic cc_hazard_c;
    logic stall_c;
    logic annul_c;

    // Picks the youngest in-flight producer of register s; %g0 never forwards,
    // and a load in EX has no data yet so it cannot forward from EX.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] s,
        input logic [4:0] ex_rd,  input logic ex_ok,
        input logic [4:0] mem_rd, input logic mem_ok,
        input logic [4:0] wb_rd,  input logic wb_ok
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (s != 5'd0) begin
            if (ex_ok && ex_rd == s)        sel = 2'b01;
            else if (mem_ok && mem_rd == s) sel = 2'b10;
            else if (wb_ok && wb_rd == s)   sel = 2'b11;
        end
        return sel;
    endfunction

    // Hazard detection: memory freeze outranks the one-bubble stall, which outranks the annul.
    always_comb begin
        hold_c      = MEM_load_instr & ~DM_ready;
        load_use_c  = EX_load_instr & EX_RF_enable & (EX_rd != 5'd0) &
                      ((EX_rd == ID_rs1) |
                       (~ID_i_bit & (EX_rd == ID_rs2)) |
                       (ID_store & (EX_rd == ID_rd)));
        cc_hazard_c = ID_B_instr & EX_modifyCC;
        stall_c     = ~hold_c & (load_use_c | cc_hazard_c);
        annul_c     = ~hold_c & ~stall_c & ID_B_instr & ID_29_a &
                      (~branch_taken | (ID_cond == COND_BA));
    end

    // Load enables, flush, NOP select and freeze, forced to safe values while in reset.
    always_comb begin
        PC_LE       = 1'b1;
        nPC_LE      = 1'b1;
        IF_ID_LE    = 1'b1;
        IF_ID_flush = 1'b0;
        mux_S       = 1'b0;
        pipe_hold   = 1'b0;
        if (R) begin
            PC_LE    = 1'b0;
            nPC_LE   = 1'b0;
            IF_ID_LE = 1'b0;
            mux_S    = 1'b1;
        end else if (hold_c) begin
            PC_LE     = 1'b0;
            nPC_LE    = 1'b0;
            IF_ID_LE  = 1'b0;
            pipe_hold = 1'b1;
        end else if (stall_c) begin
            PC_LE    = 1'b0;
            nPC_LE   = 1'b0;
            IF_ID_LE = 1'b0;
            mux_S    = 1'b1;
        end else if (annul_c) begin
            IF_ID_flush = 1'b1;
        end
    end

    // Forwarding selects for operand A (rs1), operand B (rs2) and store data (rd).
    always_comb begin
        fwd_A = 2'b00;
        fwd_B = 2'b00;
        fwd_C = 2'b00;
        if (!R) begin
            fwd_A = fwd_sel(ID_rs1, EX_rd, EX_RF_enable & ~EX_load_instr,
                            MEM_rd, MEM_RF_enable, WB_rd, WB_RF_enable);
            if (!ID_i_bit)
                fwd_B = fwd_sel(ID_rs2, EX_rd, EX_RF_enable & ~EX_load_instr,
                                MEM_rd, MEM_RF_enable, WB_rd, WB_RF_enable);
            if (ID_store)
                fwd_C = fwd_sel(ID_rd, EX_rd, EX_RF_enable & ~EX_load_instr,
                                MEM_rd, MEM_RF_enable, WB_rd, WB_RF_enable);
        end
    end

    // Memory-wait FSM: wait_cnt holds the number of wait cycles already elapsed,
    // so the timeout fires at the end of the MAX_WAIT-th consecutive wait cycle.
    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (hold_c) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (DM_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles lost to either the freeze or a bubble.
    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            stall_count <= '0;
        end else if ((hold_c | stall_c) && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign dbg_state = (state == MEM_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by randomized
// traffic, every cycle compared against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             Clk;
    logic             R;
    logic [4:0]       ID_rs1, ID_rs2, ID_rd;
    logic             ID_i_bit, ID_store, ID_B_instr, ID_29_a;
    logic [3:0]       ID_cond;
    logic             branch_taken;
    logic [4:0]       EX_rd, MEM_rd, WB_rd;
    logic             EX_RF_enable, MEM_RF_enable, WB_RF_enable;
    logic             EX_load_instr, EX_modifyCC, MEM_load_instr, DM_ready;
    logic             PC_LE, nPC_LE, IF_ID_LE, IF_ID_flush, mux_S, pipe_hold;
    logic [1:0]       fwd_A, fwd_B, fwd_C;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic             dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_stall = 0;
    bit m_to    = 0;
    int m_run   = 0;
    bit m_h     = 0;
    bit m_s     = 0;

    pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .R(R),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_i_bit(ID_i_bit), .ID_store(ID_store), .ID_B_instr(ID_B_instr),
        .ID_29_a(ID_29_a), .ID_cond(ID_cond), .branch_taken(branch_taken),
        .EX_rd(EX_rd), .MEM_rd(MEM_rd), .WB_rd(WB_rd),
        .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable),
        .WB_RF_enable(WB_RF_enable), .EX_load_instr(EX_load_instr),
        .EX_modifyCC(EX_modifyCC), .MEM_load_instr(MEM_load_instr),
        .DM_ready(DM_ready),
        .PC_LE(PC_LE), .nPC_LE(nPC_LE), .IF_ID_LE(IF_ID_LE),
        .IF_ID_flush(IF_ID_flush), .mux_S(mux_S), .pipe_hold(pipe_hold),
        .fwd_A(fwd_A), .fwd_B(fwd_B), .fwd_C(fwd_C),
        .mem_timeout(mem_timeout), .stall_count(stall_count),
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    // Forward source: first stage (youngest first) whose valid result targets s.
    function automatic int m_fwd(input int s);
        int rds[3];
        bit ok[3];
        if (s == 0) return 0;
        rds = '{int'(EX_rd), int'(MEM_rd), int'(WB_rd)};
        ok  = '{EX_RF_enable && !EX_load_instr, MEM_RF_enable, WB_RF_enable};
        for (int k = 0; k < 3; k++)
            if (ok[k] && rds[k] == s) return k + 1;
        return 0;
    endfunction

    // Evaluate the rules for the current inputs and compare every output.
    task automatic eval_cycle();
        int srcs[$];
        bit lu, cch, an;
        int e_le, e_flush, e_mux, e_hold, e_a, e_b, e_c, e_stall, e_to, e_dbg;
        @(negedge Clk);
        if (R) begin
            m_h = 0; m_s = 0;
            e_le = 0; e_flush = 0; e_mux = 1; e_hold = 0;
            e_a = 0; e_b = 0; e_c = 0; e_stall = 0; e_to = 0; e_dbg = 0;
        end else begin
            m_h = MEM_load_instr && !DM_ready;
            srcs.push_back(int'(ID_rs1));
            if (!ID_i_bit) srcs.push_back(int'(ID_rs2));
            if (ID_store)  srcs.push_back(int'(ID_rd));
            lu = 0;
            if (EX_load_instr && EX_RF_enable && EX_rd != 0)
                foreach (srcs[k]) if (srcs[k] == int'(EX_rd)) lu = 1;
            cch = ID_B_instr && EX_modifyCC;
            m_s = !m_h && (lu || cch);
            an  = !m_h && !m_s && ID_B_instr && ID_29_a && (!branch_taken || ID_cond == 4'd8);
            e_le    = (m_h || m_s) ? 0 : 1;
            e_flush = an ? 1 : 0;
            e_mux   = m_s ? 1 : 0;
            e_hold  = m_h ? 1 : 0;
            e_a     = m_fwd(int'(ID_rs1));
            e_b     = ID_i_bit ? 0 : m_fwd(int'(ID_rs2));
            e_c     = ID_store ? m_fwd(int'(ID_rd)) : 0;
            e_stall = m_stall;
            e_to    = m_to ? 1 : 0;
            e_dbg   = (m_run > 0) ? 1 : 0;
        end
        check("m_PC_LE", int'(PC_LE), e_le);
        check("m_nPC_LE", int'(nPC_LE), e_le);
        check("m_IF_ID_LE", int'(IF_ID_LE), e_le);
        check("m_flush", int'(IF_ID_flush), e_flush);
        check("m_mux_S", int'(mux_S), e_mux);
        check("m_pipe_hold", int'(pipe_hold), e_hold);
        check("m_fwd_A", int'(fwd_A), e_a);
        check("m_fwd_B", int'(fwd_B), e_b);
        check("m_fwd_C", int'(fwd_C), e_c);
        check("m_stall_count", int'(stall_count), e_stall);
        check("m_mem_timeout", int'(mem_timeout), e_to);
        check("m_state", int'(dbg_state), e_dbg);
    endtask

    // Clock edge: registered model state follows the cycle just evaluated.
    task automatic advance();
        @(posedge Clk);
        if (R) begin
            m_stall = 0; m_to = 0; m_run = 0;
        end else begin
            if ((m_h || m_s) && m_stall < CNT_MAX) m_stall++;
            if (m_h) begin
                m_run++;
                if (m_run >= MAX_WAIT) m_to = 1;
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        ID_rs1 = '0; ID_rs2 = '0; ID_rd = '0;
        ID_i_bit = 0; ID_store = 0; ID_B_instr = 0; ID_29_a = 0;
        ID_cond = '0; branch_taken = 0;
        EX_rd = '0; MEM_rd = '0; WB_rd = '0;
        EX_RF_enable = 0; MEM_RF_enable = 0; WB_RF_enable = 0;
        EX_load_instr = 0; EX_modifyCC = 0; MEM_load_instr = 0; DM_ready = 1;
    endtask

    task automatic do_reset();
        R = 1;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            eval_cycle();
            check("rst_PC_LE", int'(PC_LE), 0);
            check("rst_mux_S", int'(mux_S), 1);
            advance();
        end
        R = 0;
    endtask

    int burst;

    initial begin
        R = 1;
        clear_inputs();

        // reset
        do_reset();
        eval_cycle();
        check("post_rst_PC_LE", int'(PC_LE), 1);
        check("post_rst_stall_count", int'(stall_count), 0);
        check("post_rst_timeout", int'(mem_timeout), 0);
        advance();

        // load-use bubble, then MEM forward
        EX_load_instr = 1; EX_RF_enable = 1; EX_rd = 5'd5; ID_rs1 = 5'd5;
        eval_cycle();
        check("lu_PC_LE", int'(PC_LE), 0);
        check("lu_mux_S", int'(mux_S), 1);
        advance();
        EX_load_instr = 0; EX_RF_enable = 0; EX_rd = 5'd0;
        MEM_rd = 5'd5; MEM_RF_enable = 1;
        eval_cycle();
        check("lu_fwd_A_mem", int'(fwd_A), 2);
        check("lu_no_stall", int'(PC_LE), 1);
        check("lu_stall_count", int'(stall_count), 1);
        advance();

        // forward priority
        clear_inputs();
        EX_rd = 5'd7; MEM_rd = 5'd7; WB_rd = 5'd7;
        EX_RF_enable = 1; MEM_RF_enable = 1; WB_RF_enable = 1;
        ID_rs2 = 5'd7; ID_i_bit = 0;
        eval_cycle();
        check("prio_fwd_B_ex", int'(fwd_B), 1);
        advance();
        EX_rd = 5'd0; ID_rs1 = 5'd0;
        eval_cycle();
        check("g0_fwd_A", int'(fwd_A), 0);
        advance();

        // annul cases
        clear_inputs();
        ID_B_instr = 1; ID_29_a = 1; ID_cond = 4'b0001; branch_taken = 0;
        eval_cycle();
        check("annul_not_taken", int'(IF_ID_flush), 1);
        advance();
        branch_taken = 1;
        eval_cycle();
        check("annul_taken", int'(IF_ID_flush), 0);
        advance();
        ID_cond = 4'b1000;
        eval_cycle();
        check("annul_ba", int'(IF_ID_flush), 1);
        check("annul_le", int'(PC_LE), 1);
        advance();

        // CC hazard wins over annul, annul next cycle
        ID_cond = 4'b0001; branch_taken = 0; EX_modifyCC = 1;
        eval_cycle();
        check("cch_flush", int'(IF_ID_flush), 0);
        check("cch_PC_LE", int'(PC_LE), 0);
        advance();
        EX_modifyCC = 0;
        eval_cycle();
        check("cch_then_flush", int'(IF_ID_flush), 1);
        advance();

        // memory wait with timeout
        do_reset();
        MEM_load_instr = 1; DM_ready = 0;
        for (int i = 1; i <= MAX_WAIT; i++) begin
            eval_cycle();
            check("wait_hold", int'(pipe_hold), 1);
            check("wait_no_timeout_yet", int'(mem_timeout), 0);
            advance();
        end
        DM_ready = 1;
        eval_cycle();
        check("wait_timeout", int'(mem_timeout), 1);
        check("wait_stall_count", int'(stall_count), MAX_WAIT);
        check("wait_release_hold", int'(pipe_hold), 0);
        advance();
        eval_cycle();
        check("wait_back_to_run", int'(dbg_state), 0);
        advance();

        // reset in the middle of a wait
        DM_ready = 0;
        for (int i = 0; i < 3; i++) begin
            eval_cycle();
            advance();
        end
        check("midwait_in_wait", int'(dbg_state), 1);
        R = 1;
        #1;
        check("midwait_rst_state", int'(dbg_state), 0);
        check("midwait_rst_timeout", int'(mem_timeout), 0);
        do_reset();

        // randomized traffic
        burst = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ID_rs1 = 5'($urandom_range(0, 7));
            ID_rs2 = 5'($urandom_range(0, 7));
            ID_rd  = 5'($urandom_range(0, 7));
            EX_rd  = 5'($urandom_range(0, 7));
            MEM_rd = 5'($urandom_range(0, 7));
            WB_rd  = 5'($urandom_range(0, 7));
            ID_i_bit = 1'($urandom_range(0, 1));
            ID_store = 1'($urandom_range(0, 1));
            ID_B_instr = 1'($urandom_range(0, 1));
            ID_29_a = 1'($urandom_range(0, 1));
            ID_cond = ($urandom_range(0, 2) == 0) ? 4'b1000 : 4'($urandom_range(0, 15));
            branch_taken = 1'($urandom_range(0, 1));
            EX_RF_enable = 1'($urandom_range(0, 1));
            MEM_RF_enable = 1'($urandom_range(0, 1));
            WB_RF_enable = 1'($urandom_range(0, 1));
            EX_load_instr = 1'($urandom_range(0, 1));
            EX_modifyCC = ($urandom_range(0, 3) == 0);
            if (burst == 0 && $urandom_range(0, 14) == 0) burst = $urandom_range(1, 10);
            if (burst > 0) begin
                MEM_load_instr = 1; DM_ready = 0; burst--;
            end else begin
                MEM_load_instr = 1'($urandom_range(0, 1)); DM_ready = 1;
            end
            R = ($urandom_range(0, 99) == 0);
            if (R) burst = 0;
            eval_cycle();
            advance();
        end

        // stall_count saturation
        do_reset();
        ID_B_instr = 1; EX_modifyCC = 1;
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            eval_cycle();
            advance();
        end
        eval_cycle();
        check("stall_count_saturated", int'(stall_count), CNT_MAX);
        advance();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
